// File: rtl/baccarat_pkg.sv
// Shared types and constants for the Punto Banco datapath: card rank encoding,
// deck geometry and the card shoe state encoding.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam int RANK_MIN                = 1;
    localparam int RANK_MAX                = 13;
    localparam int CARDS_PER_RANK_PER_DECK = 4;
    localparam int DECK_SIZE               = 52;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHUFFLE = 2'd1,
        PROBE   = 2'd2,
        DELIVER = 2'd3
    } shoe_state_t;

    // Folds a 4-bit random nibble onto ranks 1..13 (values 13..15 wrap to 1..3).
    function automatic card_t start_rank(input logic [3:0] v);
        return (v < 4'd13) ? card_t'(v + 4'd1) : card_t'(v - 4'd12);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR (mask 16'hB400) feeding the card shoe's
// rank selection; a zero seed is replaced by 1 so the register never locks up.
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        resetb,
    output logic [15:0] state
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state <= INIT;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/card_shoe.sv
// Card shoe: per-rank inventory of NUM_DECKS decks, deals one random rank per
// request. Optional forced-deal ports are enabled by defining CARD_SHOE_FORCE_EN.
module card_shoe
    import baccarat_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       req,
    input  logic       shuffle,
`ifdef CARD_SHOE_FORCE_EN
    input  logic       force_valid,
    input  logic [3:0] force_card,
    output logic       force_err,
`endif
    output logic       busy,
    output logic       card_valid,
    output logic [3:0] card,
    output logic [8:0] remaining
);

    localparam logic [5:0] FULL_RANK = 6'(CARDS_PER_RANK_PER_DECK * NUM_DECKS);
    localparam logic [8:0] FULL_SHOE = 9'(DECK_SIZE * NUM_DECKS);

    shoe_state_t state;
    card_t       ptr;
    logic        refill_deal;
    logic [5:0]  cnt [RANK_MIN:RANK_MAX];
    logic [15:0] lfsr;
    logic        lfsr_unused;
    logic [5:0]  ptr_cnt;
    logic [5:0]  f_cnt;
    logic        hit;
    logic        force_ok;
    logic        fv;
    card_t       fc;

    card_lfsr #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .resetb (resetb),
        .state  (lfsr)
    );

    // Only the low nibble picks the start rank.
    assign lfsr_unused = ^lfsr[15:4];

`ifdef CARD_SHOE_FORCE_EN
    assign fv = force_valid;
    assign fc = force_card;
`else
    assign fv = 1'b0;
    assign fc = '0;
`endif

    // Out-of-range forced ranks match no counter and read back as empty.
    always_comb begin
        ptr_cnt = '0;
        f_cnt   = '0;
        for (int i = RANK_MIN; i <= RANK_MAX; i++) begin
            if (ptr == card_t'(i)) ptr_cnt = cnt[i];
            if (fc == card_t'(i))  f_cnt   = cnt[i];
        end
    end

    assign hit        = (state == PROBE) && (ptr_cnt != 6'd0);
    assign force_ok   = (f_cnt != 6'd0);
    assign busy       = (state != IDLE);
    assign card_valid = (state == DELIVER);

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state       <= IDLE;
            ptr         <= card_t'(RANK_MIN);
            refill_deal <= 1'b0;
            card        <= '0;
            remaining   <= FULL_SHOE;
            for (int i = RANK_MIN; i <= RANK_MAX; i++) cnt[i] <= FULL_RANK;
        end else begin
            case (state)
                IDLE: begin
                    if (shuffle) begin
                        state       <= SHUFFLE;
                        refill_deal <= 1'b0;
                    end else if (fv) begin
                        if (force_ok) begin
                            state <= PROBE;
                            ptr   <= fc;
                        end
                    end else if (req) begin
                        if (remaining == 9'd0) begin
                            state       <= SHUFFLE;
                            refill_deal <= 1'b1;
                        end else begin
                            state <= PROBE;
                            ptr   <= start_rank(lfsr[3:0]);
                        end
                    end
                end
                SHUFFLE: begin
                    for (int i = RANK_MIN; i <= RANK_MAX; i++) cnt[i] <= FULL_RANK;
                    remaining <= FULL_SHOE;
                    if (refill_deal) begin
                        state <= PROBE;
                        ptr   <= start_rank(lfsr[3:0]);
                    end else begin
                        state <= IDLE;
                    end
                end
                PROBE: begin
                    if (hit) begin
                        card      <= ptr;
                        remaining <= remaining - 9'd1;
                        state     <= DELIVER;
                        for (int i = RANK_MIN; i <= RANK_MAX; i++) begin
                            if (ptr == card_t'(i)) cnt[i] <= cnt[i] - 6'd1;
                        end
                    end else begin
                        ptr <= (ptr == card_t'(RANK_MAX)) ? card_t'(RANK_MIN) : ptr + 4'd1;
                    end
                end
                DELIVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CARD_SHOE_FORCE_EN
    always_ff @(posedge clock) begin
        if (!resetb) begin
            force_err <= 1'b0;
        end else begin
            force_err <= (state == IDLE) && !shuffle && force_valid && !force_ok;
        end
    end
`endif

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe (NUM_DECKS=1, SEED=16'hACE1): table-driven
// control vectors, hand sequences for corners, and random deals vs a reference model.
module tb_card_shoe;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       req = 1'b0;
    logic       shuffle = 1'b0;
    logic       busy;
    logic       card_valid;
    logic [3:0] card;
    logic [8:0] remaining;
`ifdef CARD_SHOE_FORCE_EN
    logic       force_valid = 1'b0;
    logic [3:0] force_card = 4'd0;
    logic       force_err;
`endif

    card_shoe #(.NUM_DECKS(1), .SEED(16'hACE1)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .req         (req),
        .shuffle     (shuffle),
`ifdef CARD_SHOE_FORCE_EN
        .force_valid (force_valid),
        .force_card  (force_card),
        .force_err   (force_err),
`endif
        .busy        (busy),
        .card_valid  (card_valid),
        .card        (card),
        .remaining   (remaining)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: shoe as 13 rank counts, LFSR stepped once per clock.
    logic [15:0] m_lfsr;
    int m_cnt [1:13];
    int m_rem;
    int hist [1:13];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int rank_of(input logic [15:0] x);
        int v;
        v = int'(x[3:0]);
        return (v < 13) ? v + 1 : v - 12;
    endfunction

    always @(posedge clock) m_lfsr <= resetb ? lfsr_next(m_lfsr) : 16'hACE1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_refill();
        for (int r = 1; r <= 13; r++) m_cnt[r] = 4;
        m_rem = 52;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        req = 1'b0;
        shuffle = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("rst_valid", card_valid, 0);
        end
        check("rst_remaining", remaining, 52);
        check("rst_card", card, 0);
        check("rst_busy", busy, 0);
        resetb = 1'b1;
        model_refill();
        for (int r = 1; r <= 13; r++) hist[r] = 0;
        @(negedge clock);
    endtask

    // One request pulse from IDLE; expected card and latency come from the model.
    task automatic deal();
        logic [15:0] l;
        int r, k, refill, exp_lat, lat;
        refill = (m_rem == 0) ? 1 : 0;
        if (refill == 1) begin
            model_refill();
            l = lfsr_next(m_lfsr);
        end else begin
            l = m_lfsr;
        end
        r = rank_of(l);
        k = 0;
        while (m_cnt[r] == 0) begin
            r = (r == 13) ? 1 : r + 1;
            k++;
        end
        m_cnt[r]--;
        m_rem--;
        exp_lat = 2 + k + refill;
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        lat = 1;
        check("deal_busy", busy, 1);
        while (!card_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("deal_latency", lat, exp_lat);
        check("deal_card", card, r);
        check("deal_remaining", remaining, m_rem);
        if (card >= 4'd1 && card <= 4'd13) hist[card]++;
        @(negedge clock);
        check("deal_pulse_end", card_valid, 0);
        check("deal_idle", busy, 0);
    endtask

    task automatic apply_op(input int op, output int vcnt, output int bcnt);
        vcnt = 0;
        bcnt = 0;
        req = op[0];
        shuffle = op[1];
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (i == 0) begin
                req = 1'b0;
                shuffle = 1'b0;
            end
            vcnt += int'(card_valid);
            bcnt += int'(busy);
        end
    endtask

`ifdef CARD_SHOE_FORCE_EN
    task automatic force_deal(input int rank);
        int exp_err;
        exp_err = (rank < 1 || rank > 13) ? 1 : ((m_cnt[rank] == 0) ? 1 : 0);
        force_valid = 1'b1;
        force_card = 4'(rank);
        @(negedge clock);
        force_valid = 1'b0;
        check("force_err", force_err, exp_err);
        check("force_busy", busy, 1 - exp_err);
        if (exp_err == 0) begin
            @(negedge clock);
            check("force_valid_n2", card_valid, 1);
            check("force_card", card, rank);
            m_cnt[rank]--;
            m_rem--;
        end
        @(negedge clock);
        check("force_err_end", force_err, 0);
        check("force_remaining", remaining, m_rem);
    endtask
`endif

    typedef struct {
        int op;
        int exp_valid;
        int busy_min;
        int busy_max;
        int exp_rem;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int vc, bc;
        // op: bit0 = req, bit1 = shuffle
        tbl[0] = '{1, 1, 2, 14, 51};
        tbl[1] = '{1, 1, 2, 14, 50};
        tbl[2] = '{2, 0, 1, 1, 52};
        tbl[3] = '{3, 0, 1, 1, 52};
        tbl[4] = '{0, 0, 0, 0, 52};
        tbl[5] = '{1, 1, 2, 14, 51};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_op(tbl[i].op, vc, bc);
            check("tbl_valid", vc, tbl[i].exp_valid);
            check("tbl_busy_range", int'(bc >= tbl[i].busy_min && bc <= tbl[i].busy_max), 1);
            check("tbl_remaining", remaining, tbl[i].exp_rem);
        end

        // Full shoe drain, then a refill deal.
        do_reset();
        for (int i = 0; i < 52; i++) deal();
        check("drain_remaining", remaining, 0);
        for (int r = 1; r <= 13; r++) check("drain_rank_count", hist[r], 4);
        deal();
        check("refill_remaining", remaining, 51);

        // Shuffle wins over a simultaneous request.
        do_reset();
        for (int i = 0; i < 10; i++) deal();
        req = 1'b1;
        shuffle = 1'b1;
        @(negedge clock);
        req = 1'b0;
        shuffle = 1'b0;
        check("both_busy", busy, 1);
        check("both_valid", card_valid, 0);
        @(negedge clock);
        check("both_remaining", remaining, 52);
        check("both_busy_end", busy, 0);
        check("both_valid_end", card_valid, 0);
        model_refill();

        // Random deals with idle gaps and occasional shuffles.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            if ($urandom_range(0, 19) == 0) begin
                shuffle = 1'b1;
                @(negedge clock);
                shuffle = 1'b0;
                check("rnd_shuffle_busy", busy, 1);
                @(negedge clock);
                check("rnd_shuffle_remaining", remaining, 52);
                model_refill();
            end
            deal();
        end

        // Reset while probing aborts the deal.
        do_reset();
        for (int i = 0; i < 5; i++) deal();
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        check("abort_busy", busy, 1);
        resetb = 1'b0;
        @(negedge clock);
        check("abort_valid", card_valid, 0);
        check("abort_busy_idle", busy, 0);
        check("abort_remaining", remaining, 52);
        resetb = 1'b1;
        model_refill();
        repeat (3) begin
            @(negedge clock);
            check("abort_no_valid", card_valid, 0);
        end
        deal();

`ifdef CARD_SHOE_FORCE_EN
        do_reset();
        for (int i = 0; i < 4; i++) force_deal(7);
        force_deal(7);
        check("force_rem_48", remaining, 48);
        force_deal(14);
        force_deal(0);
        check("force_rem_still_48", remaining, 48);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
# card_shoe

Card source for the Punto Banco datapath: holds an inventory of `NUM_DECKS` standard 52-card decks and, on request, deals one card in the 4-bit rank encoding (1 = A, 2–10, 11 = J, 12 = Q, 13 = K) consumed by the hand-scoring logic. Rank choice comes from a free-running LFSR. Only ranks with remaining inventory are dealt. The shoe refills automatically when exhausted and on explicit shuffle.

## Interface
- `NUM_DECKS`, default 1: decks in the shoe; legal range 1–8.
- `SEED`, default 16'hACE1: LFSR reset value. 16'h0000 is replaced by 16'h0001.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `resetb` input 1: reset; one clock; reset is synchronous and active-low.
- `req` input 1: deal request; sampled only in IDLE.
- `shuffle` input 1: refill request; sampled only in IDLE.
- `busy` output 1: high in every state except IDLE.
- `card_valid` output 1: one-cycle pulse; the dealt card is on `card`.
- `card` output 4: last dealt rank; held until the next deal; never 0, 14 or 15 after a deal.
- `remaining` output 9: total cards left in the shoe, 0 to 52·NUM_DECKS.

## Operation
- Inventory: 13 per-rank counters, 6 bits each, reset/refill value 4·NUM_DECKS. `remaining` is the sum of the counters and is kept as a registered counter.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400). Advances every cycle in every state, including during reset-release cycles after reset deasserts. Start rank: v = lfsr[3:0]; r = v+1 if v<13, else v−12.
- States:
  - IDLE:
    - `shuffle`=1 → SHUFFLE. Shuffle has priority; a simultaneous `req` is dropped.
    - Otherwise `req`=1 → SHUFFLE if `remaining`==0, else PROBE with the probe pointer loaded from r.
    - `req`/`shuffle` in any other state are ignored, not queued.
  - SHUFFLE: all counters ← 4·NUM_DECKS; `remaining` ← 52·NUM_DECKS.
    - Entered from `shuffle` → IDLE.
    - Entered from an empty-shoe `req` → PROBE, pointer loaded from r in that cycle.
  - PROBE:
    - If count[ptr]>0: decrement count[ptr] and `remaining`, latch `card`←ptr → DELIVER.
    - Else ptr ← ptr==13 ? 1 : ptr+1; stay in PROBE.
    - A hit is guaranteed within 13 probes.
  - DELIVER: `card_valid`=1 for this cycle only → IDLE.
- Reset: state IDLE, counters full, `remaining`=52·NUM_DECKS, `card`=0, `card_valid`=0, `busy`=0, LFSR=SEED. A reset mid-PROBE or mid-DELIVER aborts the deal: no `card_valid`, and no decrement persists.

## Timing
- `req` high at edge N in IDLE with a first-probe hit → `card_valid` high in cycle N+2. `busy` is high in cycles N+1 and N+2.
- Each probe miss adds 1 cycle. Worst case is 12 misses, so `card_valid` is at N+14.
- Empty shoe adds 1 cycle (SHUFFLE) before PROBE.
- Explicit shuffle: `busy` high for exactly 1 cycle; next `req` is accepted at N+2.
- Back-to-back: `req` held high is re-sampled in the cycle after DELIVER (IDLE). Minimum deal period is 3 cycles.

## Configuration
- `CARD_SHOE_FORCE_EN`: when defined, adds ports `force_valid` (in, 1), `force_card` (in, 4) and `force_err` (out, 1, reset 0).
  - In IDLE, priority is `shuffle` > `force_valid` > `req`.
  - A forced rank 1–13 with count>0 goes straight to PROBE with ptr=force_card and a guaranteed hit. `card_valid` follows at N+2, with a normal decrement.
  - A rank of 0, 14 or 15, or a rank with count 0, pulses `force_err` at N+1, deals nothing and returns to IDLE.
- When not defined: the ports are absent, and behaviour is identical to the macro-defined build with `force_valid` tied 0.

## Structure
- Shared package `baccarat_pkg`:
  - typedef `card_t` (logic [3:0]).
  - Constants `RANK_MIN`=1, `RANK_MAX`=13, `CARDS_PER_RANK_PER_DECK`=4, `DECK_SIZE`=52.
  - Shoe state enum: IDLE, SHUFFLE, PROBE, DELIVER.
- Sub-module `card_lfsr`: parameter SEED; ports clock, resetb, state[15:0]. The rank mapping stays in card_shoe.

## Test plan
- Reset, NUM_DECKS=1: `remaining`=52, `card`=0, `busy`=0; `card_valid` never high while `resetb`=0.
- 52 consecutive `req` → 52 pulses; each rank dealt exactly 4 times; `remaining` reaches 0. The 53rd `req` takes SHUFFLE, deals, and leaves `remaining`=51.
- Reference-model compare, SEED=16'hACE1, 200 deals: `card` and `card_valid` cycle match a model of the LFSR, probe and skip behaviour; latency is always 2–14 (+1 on refill).
- `req`+`shuffle` in the same IDLE cycle after 10 deals → no `card_valid`, `remaining`=52 next cycle, `busy` 1 cycle.
- Force build: force 4 of rank 7 → `card`=7 ×4 at N+2 each; a 5th force of 7 → `force_err` pulse, `remaining`=48. Force 14 → `force_err`, no change.
- `resetb` low during PROBE → next cycle IDLE, `remaining`=52·NUM_DECKS, no `card_valid`.
